// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit -- instruction-fetch front end.
//
// Owns the PC and fetches 32-bit words over a req/ack instruction-memory port.
// Each word is presented with its PC to decode over a valid/ready handshake. A
// controller redirect (i_pcsel/i_target) restarts the fetch stream at the target.
// If the bus never answers, the unit parks in a terminal error state.
//
// Parameters:
//   RESET_VECTOR  PC loaded at reset
//   NOP_INSTR     instruction driven while o_valid=0
//   ACK_TIMEOUT   cycles without i_imem_ack before o_bus_err (1..255)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   o_imem_req/o_imem_addr     fetch request, held until ack; address stable meanwhile
//   i_imem_ack/i_imem_rdata    one-cycle completion strobe with read data
//   o_valid/i_ready            decode handshake for o_instruction/o_pc
//   i_pcsel/i_target           redirect request and target (bit 0 ignored)
//   o_bus_err                  sticky fetch-timeout flag
//   o_misaligned               sticky misaligned-redirect flag (FETCH_MISALIGN_TRAP_EN only)
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN. When defined, a redirect with
// i_target[1]=1 traps into the error state instead of fetching a 2-byte aligned PC.

module rv32_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   parameter int unsigned ACK_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc,
   input  logic        i_pcsel,
   input  logic [31:0] i_target,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        o_misaligned,
`endif
   output logic        o_bus_err
);

   typedef enum logic [2:0] {
      StReq,
      StWait,
      StHold,
      StDrop,
      StErr
   } state_e;

   localparam logic [7:0] TimerLast = 8'(ACK_TIMEOUT - 1);

   state_e      state_q;
   logic [31:0] pc_q;
   logic [7:0]  timer_q;

   logic        trap;
   logic        redirect;
   logic        timeout;
   logic [31:0] redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign trap = i_pcsel & i_target[1];
`else
   assign trap = 1'b0;
`endif

   // Bit 0 of the target is always dropped.
   logic unused_target_bit0;
   assign unused_target_bit0 = i_target[0];

   assign redirect    = i_pcsel & ~trap;
   assign redirect_pc = {i_target[31:1], 1'b0};
   assign timeout     = ((state_q == StWait) || (state_q == StDrop)) && !i_imem_ack &&
                        (timer_q == TimerLast);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StReq;
         pc_q          <= RESET_VECTOR;
         timer_q       <= '0;
         o_imem_req    <= 1'b0;
         o_imem_addr   <= '0;
         o_valid       <= 1'b0;
         o_instruction <= NOP_INSTR;
         o_pc          <= '0;
         o_bus_err     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         o_misaligned  <= 1'b0;
`endif
      end else begin
         // Timer only survives while a request is outstanding and unanswered.
         timer_q <= '0;

         unique case (state_q)
            StReq: begin
               if (redirect) begin
                  pc_q <= redirect_pc;
               end else begin
                  o_imem_req  <= 1'b1;
                  o_imem_addr <= pc_q;
                  state_q     <= StWait;
               end
            end

            StWait: begin
               if (redirect) begin
                  pc_q <= redirect_pc;
                  if (i_imem_ack) begin
                     // Word arrived for the old stream: drop it.
                     o_imem_req <= 1'b0;
                     state_q    <= StReq;
                  end else begin
                     // Bus transaction must still complete before refetching.
                     timer_q <= timer_q + 8'd1;
                     state_q <= StDrop;
                  end
               end else if (i_imem_ack) begin
                  o_imem_req    <= 1'b0;
                  o_instruction <= i_imem_rdata;
                  o_pc          <= pc_q;
                  o_valid       <= 1'b1;
                  pc_q          <= pc_q + 32'd4;
                  state_q       <= StHold;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end

            StHold: begin
               // A redirect overrides; a same-cycle i_ready is still an accept.
               if (redirect) begin
                  pc_q          <= redirect_pc;
                  o_valid       <= 1'b0;
                  o_instruction <= NOP_INSTR;
                  state_q       <= StReq;
               end else if (i_ready) begin
                  o_valid       <= 1'b0;
                  o_instruction <= NOP_INSTR;
                  state_q       <= StReq;
               end
            end

            StDrop: begin
               if (redirect) begin
                  pc_q <= redirect_pc;
               end
               if (i_imem_ack) begin
                  o_imem_req <= 1'b0;
                  state_q    <= StReq;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end

            StErr: begin
               // Terminal until reset.
            end

            default: begin
               state_q <= StReq;
            end
         endcase

         // Error entry overrides whatever the state logic chose above.
         if (timeout || (trap && (state_q != StErr))) begin
            state_q       <= StErr;
            timer_q       <= '0;
            o_imem_req    <= 1'b0;
            o_valid       <= 1'b0;
            o_instruction <= NOP_INSTR;
            if (timeout) begin
               o_bus_err <= 1'b1;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (trap) begin
               o_misaligned <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit. The bench plays instruction memory and
// decode stage; a transaction-level model tracks the next fetch address, the
// outstanding request and the instruction that should be on offer.
module tb_rv32_fetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int unsigned ACK_TO = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid;
   logic        ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        pcsel;
   logic [31:0] target;
   logic        bus_err;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   always #5 clk = ~clk;

   rv32_fetch_unit #(
      .RESET_VECTOR (32'h0000_0000),
      .NOP_INSTR    (NOP),
      .ACK_TIMEOUT  (ACK_TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ack    (imem_ack),
      .i_imem_rdata  (imem_rdata),
      .o_valid       (valid),
      .i_ready       (ready),
      .o_instruction (instruction),
      .o_pc          (pc),
      .i_pcsel       (pcsel),
      .i_target      (target),
`ifdef FETCH_MISALIGN_TRAP_EN
      .o_misaligned  (misaligned),
`endif
      .o_bus_err     (bus_err)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [64];

   // Reference model state.
   bit          outstanding;
   bit          cancelled;
   bit          exp_valid;
   bit          req_next;
   logic [31:0] out_addr;
   logic [31:0] exp_next;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;
   int          lat;

   // Stimulus knobs.
   int          max_lat   = 0;
   int          force_lat = -1;
   int          ready_pct = 100;
   int          redir_pct = 0;
   bit          shot_req  = 0;
   bit          shot_ack  = 0;
   logic [31:0] shot_tgt  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem[a[7:2]];
   endfunction

   task automatic drive_idle();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      pcsel      = 1'b0;
      target     = $urandom;
      ready      = 1'b0;
   endtask

   // Reset for one edge, check reset values, release. Optionally drive a stale ack
   // into the first post-reset edge, which must be ignored.
   task automatic do_reset(input bit late_ack);
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_valid", valid, 0);
      check("rst_instr", instruction, NOP);
      check("rst_pc", pc, 0);
      check("rst_bus_err", bus_err, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misaligned", misaligned, 0);
`endif
      rst_n    = 1'b1;
      imem_ack = late_ack;
      outstanding = 0;
      cancelled   = 0;
      exp_valid   = 0;
      req_next    = 1;
      exp_next    = 32'h0000_0000;
   endtask

   // One cycle: check outputs against the model at the negedge, then drive inputs
   // for the next rising edge and advance the model across it.
   task automatic step();
      bit          redir;
      bit          ack;
      bit          rdy;
      bit          first;
      logic [31:0] tgt;
      @(negedge clk);
      first = 0;
      if (exp_valid) begin
         check("valid_hi", valid, 1);
         check("out_pc", pc, exp_pc);
         check("out_instr", instruction, exp_instr);
      end else begin
         check("valid_lo", valid, 0);
         check("nop_instr", instruction, NOP);
      end
      check("bus_err_lo", bus_err, 0);
      if (outstanding) begin
         check("req_held", imem_req, 1);
         check("addr_stable", imem_addr, out_addr);
      end else if (exp_valid || !req_next) begin
         check("req_lo", imem_req, 0);
      end else begin
         check("req_hi", imem_req, 1);
         check("fetch_addr", imem_addr, exp_next);
         outstanding = 1;
         cancelled   = 0;
         first       = 1;
         out_addr    = exp_next;
         lat         = (force_lat >= 0) ? force_lat : int'($urandom_range(0, max_lat));
      end

      ack = 0;
      if (outstanding) begin
         if (lat == 0) ack = 1;
         else lat--;
      end
      redir = ($urandom_range(0, 99) < redir_pct);
      tgt   = {24'h0, 6'($urandom_range(0, 63)), 1'b0, 1'($urandom_range(0, 1))};
      if (shot_req && first) begin
         redir    = 1;
         tgt      = shot_tgt;
         shot_req = 0;
      end
      if (shot_ack && ack) begin
         redir    = 1;
         tgt      = shot_tgt;
         shot_ack = 0;
      end
      rdy = exp_valid ? ($urandom_range(0, 99) < ready_pct) : 1'($urandom_range(0, 1));

      imem_ack   = ack;
      imem_rdata = ack ? mem_word(out_addr) : $urandom;
      pcsel      = redir;
      target     = redir ? tgt : $urandom;
      ready      = rdy;

      if (outstanding) begin
         if (redir) begin
            exp_next = tgt & 32'hFFFF_FFFE;
            if (ack) begin
               outstanding = 0;
               req_next    = 0;
            end else begin
               cancelled = 1;
            end
         end else if (ack) begin
            outstanding = 0;
            if (cancelled) begin
               req_next = 0;
            end else begin
               exp_valid = 1;
               exp_pc    = out_addr;
               exp_instr = mem_word(out_addr);
               exp_next  = out_addr + 32'd4;
            end
         end
      end else if (exp_valid) begin
         if (redir || rdy) begin
            exp_valid = 0;
            req_next  = 0;
         end
         if (redir) exp_next = tgt & 32'hFFFF_FFFE;
      end else begin
         if (redir) begin
            exp_next = tgt & 32'hFFFF_FFFE;
            req_next = 0;
         end else begin
            req_next = 1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit early;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      rst_n = 1'b0;
      drive_idle();

      // Back-to-back fetches, zero ack latency, decode always ready: 0,4,8,12.
      do_reset(0);
      run(12);
      check("seq_next_addr", exp_next, 32'h0000_0010);

      // Decode stalls: held word must stay put with no new request.
      ready_pct = 0;
      run(10);
      ready_pct = 100;
      run(3);

      // Redirect to an odd target while waiting, ack three cycles later.
      force_lat = 3;
      shot_req  = 1;
      shot_tgt  = 32'h0000_0101;
      run(12);
      force_lat = -1;

      // Redirect in the same cycle as the ack.
      max_lat  = 2;
      shot_ack = 1;
      shot_tgt = 32'h0000_0200;
      run(10);

      // Fetch at the top of the address space wraps to zero.
      shot_req = 1;
      shot_tgt = 32'hFFFF_FFFC;
      run(15);

`ifndef FETCH_MISALIGN_TRAP_EN
      // Bit 1 of the target is honoured without the trap.
      shot_req = 1;
      shot_tgt = 32'h0000_0103;
      run(10);
`endif

      // Random traffic: latency, stalls and redirects.
      max_lat   = 3;
      ready_pct = 60;
      redir_pct = 15;
      run(600);

      // Reset in the middle of a fetch; stale ack after reset is ignored.
      redir_pct = 0;
      for (int i = 0; i < 10 && !outstanding; i++) step();
      check("mid_fetch_outstanding", outstanding, 1);
      do_reset(1);
      ready_pct = 100;
      run(10);

      // Timeout: request stays up and unanswered.
      do_reset(0);
      @(negedge clk);
      check("to_req", imem_req, 1);
      drive_idle();
      early = 0;
      for (int i = 1; i < ACK_TO; i++) begin
         @(negedge clk);
         if (bus_err !== 1'b0 || imem_req !== 1'b1) early = 1;
      end
      check("to_no_early_err", early, 0);
      @(negedge clk);
      check("to_bus_err", bus_err, 1);
      check("to_req_drop", imem_req, 0);
      check("to_valid", valid, 0);
      pcsel  = 1'b1;
      target = 32'h0000_0040;
      for (int i = 0; i < 10; i++) begin
         imem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      check("err_sticky", bus_err, 1);
      check("err_no_req", imem_req, 0);
      check("err_no_valid", valid, 0);
      do_reset(0);
      run(6);

`ifdef FETCH_MISALIGN_TRAP_EN
      // Misaligned redirect traps.
      do_reset(0);
      @(negedge clk);
      check("mis_req", imem_req, 1);
      imem_ack = 1'b0;
      pcsel    = 1'b1;
      target   = 32'h0000_0002;
      @(negedge clk);
      drive_idle();
      check("mis_flag", misaligned, 1);
      check("mis_req_drop", imem_req, 0);
      check("mis_valid", valid, 0);
      check("mis_bus_err", bus_err, 0);
      repeat (5) @(negedge clk);
      check("mis_sticky", misaligned, 1);
      check("mis_no_req", imem_req, 0);
      do_reset(0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
